// File: rtl/pipeline_mode_ctrl.sv
// Pipeline mode controller: drives global stall/squash for run, flush, memory-wait and load modes.
// Optional wait watchdog enabled by defining MODE_WAIT_TIMEOUT_EN.
module pipeline_mode_ctrl #(
    parameter int NUM_MEM_PORTS = 2,
    parameter int FLUSH_CYCLES  = 3,
    parameter int WAIT_TIMEOUT  = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     branch_jump,
    input  logic                     load_req,
    input  logic [NUM_MEM_PORTS-1:0] request_done,
    output logic                     master_hold,
    output logic                     flush_hold,
    output logic                     load_mode,
    output logic [1:0]               mode,
    output logic                     wait_timeout
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        FLUSH    = 2'b01,
        MEM_WAIT = 2'b10,
        LOAD     = 2'b11
    } state_t;

    if (NUM_MEM_PORTS < 1 || FLUSH_CYCLES < 1 || WAIT_TIMEOUT < 1) begin : g_bad_param
        $error("pipeline_mode_ctrl: NUM_MEM_PORTS, FLUSH_CYCLES and WAIT_TIMEOUT must be >= 1");
    end

    state_t        state, state_nxt;
    logic [CW-1:0] flush_cnt, flush_cnt_nxt;
    logic          pending_flush, pending_flush_nxt;
    logic          mem_wait;

    assign mem_wait = ~&request_done;

    always_comb begin
        state_nxt         = state;
        flush_cnt_nxt     = flush_cnt;
        pending_flush_nxt = pending_flush;
        case (state)
            RUN: begin
                if (load_req) begin
                    state_nxt = LOAD;
                end else if (mem_wait) begin
                    state_nxt = MEM_WAIT;
                    if (branch_jump) pending_flush_nxt = 1'b1;
                end else if (branch_jump) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = CW'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (flush_cnt != '0) flush_cnt_nxt = flush_cnt - 1'b1;
                else                 state_nxt     = RUN;
            end
            MEM_WAIT: begin
                if (mem_wait) begin
                    if (branch_jump) pending_flush_nxt = 1'b1;
                end else if (pending_flush || branch_jump) begin
                    state_nxt         = FLUSH;
                    flush_cnt_nxt     = CW'(FLUSH_CYCLES - 1);
                    pending_flush_nxt = 1'b0;
                end else begin
                    state_nxt = RUN;
                end
            end
            LOAD: begin
                if (!load_req) begin
                    state_nxt         = RUN;
                    pending_flush_nxt = 1'b0;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            flush_cnt     <= '0;
            pending_flush <= 1'b0;
            master_hold   <= 1'b0;
            flush_hold    <= 1'b0;
            load_mode     <= 1'b0;
            mode          <= 2'b00;
        end else begin
            state         <= state_nxt;
            flush_cnt     <= flush_cnt_nxt;
            pending_flush <= pending_flush_nxt;
            master_hold   <= (state_nxt == MEM_WAIT) || (state_nxt == LOAD);
            flush_hold    <= (state_nxt == FLUSH);
            load_mode     <= (state_nxt == LOAD);
            mode          <= state_nxt;
        end
    end

`ifdef MODE_WAIT_TIMEOUT_EN
    localparam int WCW = $clog2(WAIT_TIMEOUT + 1);

    logic [WCW-1:0] wait_cnt;

    // Counts completed MEM_WAIT cycles, saturating; flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt     <= '0;
            wait_timeout <= 1'b0;
        end else if (state != MEM_WAIT && state_nxt == MEM_WAIT) begin
            wait_cnt <= '0;
        end else if (state == MEM_WAIT && wait_cnt != WCW'(WAIT_TIMEOUT)) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WCW'(WAIT_TIMEOUT - 1)) wait_timeout <= 1'b1;
        end
    end
`else
    assign wait_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_mode_ctrl.sv
// Directed bench for pipeline_mode_ctrl: three instances covering 2/3/1 ports and flush lengths 3/1/2.
module tb_pipeline_mode_ctrl;

`ifdef MODE_WAIT_TIMEOUT_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    // {load_mode, flush_hold, master_hold, mode}
    localparam logic [4:0] S_RUN = 5'b00000;
    localparam logic [4:0] S_FL  = 5'b01001;
    localparam logic [4:0] S_MW  = 5'b00110;
    localparam logic [4:0] S_LD  = 5'b10111;

    logic       clk = 1'b0;
    logic       rst, bj, lr;
    logic [1:0] rd2;
    logic [2:0] rd3;
    logic [0:0] rd1;

    logic       mh_a, fh_a, lm_a, wt_a;
    logic [1:0] md_a;
    logic       mh_b, fh_b, lm_b, wt_b;
    logic [1:0] md_b;
    logic       mh_c, fh_c, lm_c, wt_c;
    logic [1:0] md_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipeline_mode_ctrl #(.NUM_MEM_PORTS(2), .FLUSH_CYCLES(3), .WAIT_TIMEOUT(8)) u_a (
        .clk(clk), .rst(rst), .branch_jump(bj), .load_req(lr), .request_done(rd2),
        .master_hold(mh_a), .flush_hold(fh_a), .load_mode(lm_a), .mode(md_a), .wait_timeout(wt_a));

    pipeline_mode_ctrl #(.NUM_MEM_PORTS(3), .FLUSH_CYCLES(1), .WAIT_TIMEOUT(8)) u_b (
        .clk(clk), .rst(rst), .branch_jump(bj), .load_req(1'b0), .request_done(rd3),
        .master_hold(mh_b), .flush_hold(fh_b), .load_mode(lm_b), .mode(md_b), .wait_timeout(wt_b));

    pipeline_mode_ctrl #(.NUM_MEM_PORTS(1), .FLUSH_CYCLES(2), .WAIT_TIMEOUT(8)) u_c (
        .clk(clk), .rst(rst), .branch_jump(bj), .load_req(1'b0), .request_done(rd1),
        .master_hold(mh_c), .flush_hold(fh_c), .load_mode(lm_c), .mode(md_c), .wait_timeout(wt_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [4:0] exp);
        chk(tag, {lm_a, fh_a, mh_a, md_a}, exp);
    endtask

    task automatic chk_wt(input string tag, input logic exp);
        chk(tag, {4'b0, wt_a}, {4'b0, exp});
    endtask

    initial begin
        rst = 1'b1; bj = 1'b0; lr = 1'b0; rd2 = 2'b11; rd3 = 3'b111; rd1 = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk_a("reset_a", S_RUN);
        chk("reset_b", {lm_b, fh_b, mh_b, md_b}, S_RUN);
        chk("reset_c", {lm_c, fh_c, mh_c, md_c}, S_RUN);
        chk("reset_wt", {2'b0, wt_a, wt_b, wt_c}, 5'b0);

        // Flush length: A=3, B=1, C=2 cycles.
        bj = 1'b1; tick(); bj = 1'b0;
        chk_a("flush_a1", S_FL);
        chk("flush_b1", {lm_b, fh_b, mh_b, md_b}, S_FL);
        chk("flush_c1", {lm_c, fh_c, mh_c, md_c}, S_FL);
        tick();
        chk_a("flush_a2", S_FL);
        chk("flush_b_end", {lm_b, fh_b, mh_b, md_b}, S_RUN);
        chk("flush_c2", {lm_c, fh_c, mh_c, md_c}, S_FL);
        tick();
        chk_a("flush_a3", S_FL);
        chk("flush_c_end", {lm_c, fh_c, mh_c, md_c}, S_RUN);
        tick();
        chk_a("flush_a_end", S_RUN);

        // Reset held two cycles mid-flush.
        bj = 1'b1; tick(); bj = 1'b0;
        chk_a("rflush_enter", S_FL);
        rst = 1'b1; tick();
        chk_a("rflush_rst1", S_RUN);
        tick(); rst = 1'b0;
        chk_a("rflush_rst2", S_RUN);
        chk_wt("rflush_wt", 1'b0);
        tick();
        chk_a("rflush_after", S_RUN);

        // Three-port memory wait on B; single-port wait on C.
        rd3 = 3'b101;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mw3_hold", {lm_b, fh_b, mh_b, md_b}, S_MW);
        end
        rd3 = 3'b111; tick();
        chk("mw3_end", {lm_b, fh_b, mh_b, md_b}, S_RUN);
        chk_a("mw3_a_idle", S_RUN);
        rd1 = 1'b0; tick();
        chk("mw1_hold", {lm_c, fh_c, mh_c, md_c}, S_MW);
        rd1 = 1'b1; tick();
        chk("mw1_end", {lm_c, fh_c, mh_c, md_c}, S_RUN);

        // Branch during wait on A: 5 wait cycles, then 3 flush cycles.
        rd2 = 2'b01;
        for (int i = 1; i <= 5; i++) begin
            bj = (i == 2);
            tick();
            chk_a("bw_hold", S_MW);
        end
        bj = 1'b0; rd2 = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_a("bw_flush", S_FL);
        end
        tick();
        chk_a("bw_run", S_RUN);

        // Branch coincident with wait entry from RUN is remembered.
        bj = 1'b1; rd2 = 2'b00; tick(); bj = 1'b0;
        chk_a("bpend_wait", S_MW);
        rd2 = 2'b11; tick();
        chk_a("bpend_flush", S_FL);
        tick(); tick(); tick();
        chk_a("bpend_run", S_RUN);
        tick(); tick(); tick();

        // Priority: load beats wait and branch; no flush afterwards.
        lr = 1'b1; bj = 1'b1; rd2 = 2'b00; tick(); bj = 1'b0; rd2 = 2'b11;
        chk_a("prio_load", S_LD);
        tick();
        chk_a("prio_stay", S_LD);
        lr = 1'b0; tick();
        chk_a("prio_exit", S_RUN);
        tick();
        chk_a("prio_noflush", S_RUN);

        // load_req ignored in MEM_WAIT, taken once back in RUN.
        rd2 = 2'b01; tick();
        chk_a("lw_wait", S_MW);
        lr = 1'b1; tick();
        chk_a("lw_ignored", S_MW);
        rd2 = 2'b11; tick();
        chk_a("lw_run", S_RUN);
        tick();
        chk_a("lw_load", S_LD);
        lr = 1'b0; tick();
        chk_a("lw_exit", S_RUN);

        // Watchdog: flag rises after the 8th completed MEM_WAIT cycle.
        rd2 = 2'b10;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk_a("wd_hold", S_MW);
            chk_wt("wd_flag", WD_ON && (i >= 9));
        end
        rd2 = 2'b11; tick();
        chk_a("wd_run", S_RUN);
        chk_wt("wd_sticky", WD_ON);
        tick();
        chk_wt("wd_sticky2", WD_ON);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_wt("wd_rst", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1);
    end

endmodule
